// File: rtl/regfile_access_ctrl_if.sv
// Request/grant handshake between the decode/writeback stages and the register-file access controller.
// "master" is the requester side and "slave" is the controller side.
interface regfile_access_ctrl_if #(
    parameter int DataSize = 32,
    parameter int AddrSize = 5
);
    logic                rd_req;
    logic [AddrSize-1:0] rd_ra_addr;
    logic [AddrSize-1:0] rd_rb_addr;
    logic                rd_gnt;
    logic                rd_data_valid;

    logic                alu_wr_req;
    logic [AddrSize-1:0] alu_wr_addr;
    logic [DataSize-1:0] alu_wr_data;
    logic                alu_wr_gnt;

    logic                mem_wr_req;
    logic [AddrSize-1:0] mem_wr_addr;
    logic [DataSize-1:0] mem_wr_data;
    logic                mem_wr_gnt;

    modport master (
        output rd_req, rd_ra_addr, rd_rb_addr,
        output alu_wr_req, alu_wr_addr, alu_wr_data,
        output mem_wr_req, mem_wr_addr, mem_wr_data,
        input  rd_gnt, rd_data_valid, alu_wr_gnt, mem_wr_gnt
    );

    modport slave (
        input  rd_req, rd_ra_addr, rd_rb_addr,
        input  alu_wr_req, alu_wr_addr, alu_wr_data,
        input  mem_wr_req, mem_wr_addr, mem_wr_data,
        output rd_gnt, rd_data_valid, alu_wr_gnt, mem_wr_gnt
    );
endinterface

// File: rtl/regfile_access_ctrl.sv
// Arbitrates one operand fetch and two writeback sources onto the register file's single
// control port: one grant per cycle, round-robin writes, bounded write bursts ahead of a read.
module regfile_access_ctrl #(
    parameter int DataSize   = 32,
    parameter int AddrSize   = 5,
    parameter int WrBurstMax = 4
) (
    input  logic                clock,
    input  logic                reset,
    regfile_access_ctrl_if.slave req,
    output logic                enable_reg_fetch,
    output logic                enable_reg_write,
    output logic                do_reg_write,
    output logic [AddrSize-1:0] reg_ra_addr,
    output logic [AddrSize-1:0] reg_rb_addr,
    output logic [AddrSize-1:0] reg_rt_addr,
    output logic [DataSize-1:0] write_reg_data
);
    localparam logic [3:0] BurstLim = 4'(WrBurstMax);

    typedef enum logic [1:0] {IDLE, FETCH, WRITE} state_t;
    typedef enum logic {PTR_ALU, PTR_MEM} ptr_t;

    state_t     state;
    ptr_t       ptr;
    logic [3:0] streak;

    logic conflict;
    logic force_rd;
    logic any_wr;
    logic rd_win;
    logic wr_win;
    logic alu_sel;

    // A forced read must not overtake a write to one of its own source registers.
    always_comb begin
        conflict = 1'b0;
        if (req.alu_wr_req && (req.rd_ra_addr == req.alu_wr_addr || req.rd_rb_addr == req.alu_wr_addr))
            conflict = 1'b1;
        if (req.mem_wr_req && (req.rd_ra_addr == req.mem_wr_addr || req.rd_rb_addr == req.mem_wr_addr))
            conflict = 1'b1;
    end

    assign any_wr   = req.alu_wr_req || req.mem_wr_req;
    assign force_rd = (streak == BurstLim) && !conflict;
    assign rd_win   = !reset && req.rd_req && (!any_wr || force_rd);
    assign wr_win   = !reset && any_wr && !rd_win;
    assign alu_sel  = req.alu_wr_req && (!req.mem_wr_req || ptr == PTR_ALU);

    assign req.rd_gnt     = rd_win;
    assign req.alu_wr_gnt = wr_win && alu_sel;
    assign req.mem_wr_gnt = wr_win && !alu_sel;

    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= IDLE;
            ptr               <= PTR_ALU;
            streak            <= '0;
            enable_reg_fetch  <= 1'b0;
            enable_reg_write  <= 1'b0;
            do_reg_write      <= 1'b0;
            reg_ra_addr       <= '0;
            reg_rb_addr       <= '0;
            reg_rt_addr       <= '0;
            write_reg_data    <= '0;
            req.rd_data_valid <= 1'b0;
        end else begin
            req.rd_data_valid <= (state == FETCH);
            enable_reg_fetch  <= rd_win;
            enable_reg_write  <= wr_win;
            do_reg_write      <= wr_win;
            reg_ra_addr       <= rd_win ? req.rd_ra_addr : '0;
            reg_rb_addr       <= rd_win ? req.rd_rb_addr : '0;
            reg_rt_addr       <= '0;
            write_reg_data    <= '0;

            if (rd_win) begin
                state <= FETCH;
            end else if (wr_win) begin
                state          <= WRITE;
                reg_rt_addr    <= alu_sel ? req.alu_wr_addr : req.mem_wr_addr;
                write_reg_data <= alu_sel ? req.alu_wr_data : req.mem_wr_data;
                ptr            <= alu_sel ? PTR_MEM : PTR_ALU;
            end else begin
                state <= IDLE;
            end

            // Saturates while a conflicting write keeps holding the read off.
            if (!req.rd_req || rd_win)
                streak <= '0;
            else if (wr_win && streak != BurstLim)
                streak <= streak + 4'd1;
        end
    end
endmodule
